// File: rtl/systolic_feeder.sv
// Feeds skewed, zero-padded operand streams from stored A/B matrices into the
// west/north edges of an NxN mac_unit array, then pulses done once results settle.
module systolic_feeder #(
  parameter int unsigned N   = 2,
  parameter int unsigned W   = 8,
  parameter int unsigned HOP = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [$clog2(N)-1:0]   wr_row,
  input  logic [$clog2(N)-1:0]   wr_col,
  input  logic [W-1:0]           wr_data,
  input  logic                   clear,
  input  logic                   start,
  output logic [N*W-1:0]         a_out,
  output logic [N*W-1:0]         b_out,
  output logic                   feed_active,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned T    = N + (N - 1) * HOP;
  localparam int unsigned D    = (2 * N - 1) * HOP;
  localparam int unsigned CMAX = (T > D) ? T : D;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   t_q, t_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N*W-1:0]  a_q, a_d, b_q, b_d;
  logic            fa_q, fa_d, busy_q, busy_d, done_q, done_d;
  logic [W-1:0]    a_mem [N][N];
  logic [W-1:0]    b_mem [N][N];
  logic            in_range;

  // Index check only matters when N is not a power of two.
  assign in_range = (32'(wr_row) < N) && (32'(wr_col) < N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_mem[i][j] <= '0;
          b_mem[i][j] <= '0;
        end
      end
    end else if (state_q == StIdle) begin
      if (clear) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            a_mem[i][j] <= '0;
            b_mem[i][j] <= '0;
          end
        end
      end else if (wr_en && in_range) begin
        if (wr_sel) b_mem[wr_row][wr_col] <= wr_data;
        else        a_mem[wr_row][wr_col] <= wr_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFeed;
          t_d     = '0;
        end
      end
      StFeed: begin
        if (t_q == CW'(T - 1)) begin
          state_d = StDrain;
          t_d     = '0;
          cnt_d   = CW'(D - 1);
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q == '0) state_d = StDone;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Row i / column j lag by i*HOP / j*HOP cycles; everything else is zero padding.
  always_comb begin
    a_d    = '0;
    b_d    = '0;
    fa_d   = (state_q == StFeed);
    busy_d = (state_q == StFeed) || (state_q == StDrain);
    done_d = (state_q == StDone);
    if (state_q == StFeed) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (t_q == CW'(i * HOP + k)) begin
            a_d[i*W +: W] = a_mem[i][k];
            b_d[i*W +: W] = b_mem[k][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      t_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fa_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fa_q    <= fa_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a_out       = a_q;
  assign b_out       = b_q;
  assign feed_active = fa_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=2, HOP=2): scoreboard of expected per-cycle
// outputs built from a behavioural skew model, plus literal spot checks.
module tb_systolic_feeder;

  localparam int N    = 2;
  localparam int W    = 8;
  localparam int HOP  = 2;
  localparam int T    = N + (N - 1) * HOP;
  localparam int D    = (2 * N - 1) * HOP;
  localparam int NOBS = T + D + 3;
  localparam int VW   = 2 * N * W + 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           wr_en = 1'b0;
  logic           wr_sel = 1'b0;
  logic [0:0]     wr_row = '0;
  logic [0:0]     wr_col = '0;
  logic [W-1:0]   wr_data = '0;
  logic           clear = 1'b0;
  logic           start = 1'b0;
  logic [N*W-1:0] a_out, b_out;
  logic           feed_active, busy, done;

  int checks = 0;
  int failures = 0;

  logic [W-1:0]   ma [N][N];
  logic [W-1:0]   mb [N][N];
  logic [VW-1:0]  expq [$];
  logic [N*W-1:0] cap_a [NOBS];
  logic [N*W-1:0] cap_b [NOBS];

  systolic_feeder #(.N(N), .W(W), .HOP(HOP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_data     (wr_data),
    .clear       (clear),
    .start       (start),
    .a_out       (a_out),
    .b_out       (b_out),
    .feed_active (feed_active),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] observe();
    return {a_out, b_out, feed_active, busy, done};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected observation j is sampled on the negedge after the j-th posedge past start.
  task automatic push_expected();
    for (int j = 0; j < NOBS; j++) begin
      logic [N*W-1:0] ea, eb;
      logic efa, ebusy, edone;
      ea = '0; eb = '0;
      efa   = (j >= 1) && (j <= T);
      ebusy = (j >= 1) && (j <= T + D);
      edone = (j == T + D + 1);
      if (efa) begin
        for (int i = 0; i < N; i++)
          for (int k = 0; k < N; k++)
            if (j - 1 == i * HOP + k) begin
              ea[i*W +: W] = ma[i][k];
              eb[i*W +: W] = mb[k][i];
            end
      end
      expq.push_back({ea, eb, efa, ebusy, edone});
    end
  endtask

  task automatic do_write(input logic sel, input int r, input int c, input logic [W-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_row = 1'(r); wr_col = 1'(c); wr_data = d;
    if (sel) mb[r][c] = d; else ma[r][c] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // inject >= 0 pulses wr_en (A[0][0]=FF) and start at that observation, mid-sequence.
  task automatic run_feed(input string tag, input int inject);
    start = 1'b1;
    push_expected();
    @(negedge clk);
    for (int j = 0; j < NOBS; j++) begin
      logic [VW-1:0] e;
      e = expq.pop_front();
      cap_a[j] = a_out;
      cap_b[j] = b_out;
      check($sformatf("%s_obs%0d", tag, j), 64'(observe()), 64'(e));
      start = 1'b0; wr_en = 1'b0;
      if (j == inject) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_row = 1'b0; wr_col = 1'b0;
        wr_data = 8'hFF;
      end
      if (j < NOBS - 1) @(negedge clk);
    end
    start = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[i][k] = '0; mb[i][k] = '0;
      end

    // Asynchronous reset seen before any clock edge.
    #1 rst_n = 1'b0;
    #2 check("reset_async", 64'(observe()), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_feed("empty", -1);

    do_write(1'b0, 0, 0, 8'h30);
    do_write(1'b0, 0, 1, 8'h38);
    do_write(1'b0, 1, 0, 8'h40);
    do_write(1'b0, 1, 1, 8'h44);
    do_write(1'b1, 0, 0, 8'h31);
    do_write(1'b1, 0, 1, 8'h32);
    do_write(1'b1, 1, 0, 8'h33);
    do_write(1'b1, 1, 1, 8'h34);
    run_feed("skew", -1);
    check("skew_a_t0", 64'(cap_a[1]), 64'h0030);
    check("skew_a_t1", 64'(cap_a[2]), 64'h0038);
    check("skew_a_t2", 64'(cap_a[3]), 64'h4000);
    check("skew_a_t3", 64'(cap_a[4]), 64'h4400);
    check("skew_b_t0", 64'(cap_b[1]), 64'h0031);
    check("skew_b_t1", 64'(cap_b[2]), 64'h0033);
    check("skew_b_t2", 64'(cap_b[3]), 64'h3200);
    check("skew_b_t3", 64'(cap_b[4]), 64'h3400);

    // Write committed in the same cycle as start is used by that feed.
    wr_en = 1'b1; wr_sel = 1'b0; wr_row = 1'b1; wr_col = 1'b1; wr_data = 8'h55;
    ma[1][1] = 8'h55;
    run_feed("collide", -1);
    check("collide_row1_t3", 64'(cap_a[4]), 64'h5500);

    // Write and start during FEED must be ignored; a rerun repeats identical streams.
    run_feed("protect", 2);
    @(negedge clk);
    run_feed("rerun", -1);
    check("rerun_a_t0", 64'(cap_a[1]), 64'h0030);

    // Abort at feed cycle 2.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_a", 64'(a_out), 64'h4000);
    rst_n = 1'b0;
    #1 check("abort_async", 64'(observe()), 64'(0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("abort_hold%0d", c), 64'(observe()), 64'(0));
    end
    rst_n = 1'b1;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[i][k] = '0; mb[i][k] = '0;
      end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("abort_nodone%0d", c), 64'(observe()), 64'(0));
    end
    run_feed("post_abort", -1);

    // Clear beats a simultaneous write.
    do_write(1'b0, 0, 1, 8'h11);
    do_write(1'b1, 1, 0, 8'h22);
    clear = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_row = 1'b0; wr_col = 1'b0;
    wr_data = 8'h7F;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[i][k] = '0; mb[i][k] = '0;
      end
    @(negedge clk);
    clear = 1'b0; wr_en = 1'b0;
    run_feed("cleared", -1);

    check("queue_empty", 64'(expq.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Transmit side of the mac_unit operand interface.
- Stores an NxN minifloat matrix A and an NxN minifloat matrix B.
- On start, drives skewed, zero-padded operand streams into the west edge (a) and north edge (b) of an NxN mac_unit array.
- Pulses done once the last product has propagated to every Mn_out; the feeder does not interpret operand bits.

Parameters:
N, 2, array dimension (rows = cols = N), 2..8
W, 8, operand width (1 sign, 3 exp, 4 fraction minifloat)
HOP, 2, register stages per mac_unit hop (a→a_pass and the Mn_out pipeline)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write one operand into storage (IDLE only)
wr_sel  in  1  0 = matrix A, 1 = matrix B
wr_row  in  clog2(N)  row index
wr_col  in  clog2(N)  column index
wr_data  in  W  operand byte
clear  in  1  synchronous zeroing of both matrices (IDLE only)
start  in  1  begin a feed sequence (IDLE only)
a_out  out  N*W  slice i (bits i*W+:W) drives a of array row i, column 0
b_out  out  N*W  slice j drives b of array row 0, column j
feed_active  out  1  high during FEED cycles
busy  out  1  high in FEED or DRAIN
done  out  1  one-cycle pulse; results valid on all Mn_out

Behaviour:
- Reset (async assert, sync release): state IDLE; A, B storage = 0; a_out = 0, b_out = 0; feed_active = 0, busy = 0, done = 0; counters = 0.
- Reset asserted mid-FEED/DRAIN aborts immediately; no done is produced.
- Storage: registered write at clk edge when wr_en && state==IDLE. Writes outside IDLE are ignored.
- Out-of-range indices (N not a power of 2) are ignored.
- clear && IDLE zeroes all entries. If clear and wr_en occur in the same cycle, clear wins.
- States: IDLE, FEED, DRAIN, DONE.
  - IDLE→FEED on start. A wr_en in the same cycle is committed, and the feed uses the updated data.
  - FEED runs T = N + (N-1)*HOP cycles, with feed cycle counter t = 0..T-1. FEED→DRAIN after t = T-1.
  - DRAIN runs D = (2N-1)*HOP cycles, with a down-counter.
  - DRAIN→DONE when the counter reaches 0.
  - DONE lasts one cycle: done = 1, then IDLE.
- start while not IDLE is ignored. Storage persists across sequences, so start may be reissued without reloading.
- Feed schedule, outputs registered (values appear the cycle after the state/t that selects them):
  - a_out[i] = A[i][k] when t = i*HOP + k, 0 <= k < N; otherwise 0.
  - b_out[j] = B[k][j] when t = j*HOP + k; otherwise 0.
  - a_out and b_out are 0 in IDLE, DRAIN and DONE.
- feed_active and busy are registered and aligned with the output cycles they describe.
- No arithmetic is performed on operands; padding is exactly 8'h00, which mac_unit treats as zero.
- Accumulator reset in the array is not this block's job.

Test Plan:
- Reset defaults: assert rst_n=0 mid-clock → all outputs 0 without a clk edge. Release, then start with empty storage → 4 FEED cycles of zeros, then done exactly 1+4+6 cycles after start (N=2, HOP=2).
- Skew check, N=2 HOP=2: A = {00:8'h30, 01:8'h38, 10:8'h40, 11:8'h44}, B = {00:8'h31, 01:8'h32, 10:8'h33, 11:8'h34}.
  - a_out row0 = 30, 38, 00, 00.
  - a_out row1 = 00, 00, 40, 44.
  - b_out col0 = 31, 33, 00, 00.
  - b_out col1 = 00, 00, 32, 34.
  - feed_active high for exactly these 4 cycles.
- Write/start collision: wr_en A[1][1]=8'h55 in the same cycle as start → row1 feed cycle 3 outputs 55.
- Protection: wr_en and start pulsed during FEED → storage unchanged; the second sequence repeats identical streams with no extra done.
- Abort: rst_n low at feed cycle 2, high 3 cycles later → outputs 0, no done pulse; storage cleared, so a fresh start streams zeros.
- Clear: load nonzero values, pulse clear together with wr_en A[0][0]=8'h7F → subsequent feed is all zeros.
